// File: rtl/nps_rom_seq.sv
// nps_rom_seq: address-stream initiator for an NPS ROM.
// On start it issues len consecutive addresses from base, emits a one-cycle
// flush strobe, then waits for the ROM frame-end while counting and summing
// the returned data words.
// Optional macro NPS_ROM_SEQ_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT
// cycles that forces completion with err_to set.
module nps_rom_seq #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADR_WIDTH  = 9,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ADR_WIDTH-1:0]            base,
  input  logic [ADR_WIDTH:0]              len,
  output logic                            vo,
  output logic                            fo,
  output logic [ADR_WIDTH-1:0]            datao,
  input  logic                            vi,
  input  logic                            fi,
  input  logic [DATA_WIDTH-1:0]           datai,
  output logic                            busy,
  output logic                            done,
  output logic [ADR_WIDTH:0]              rcnt,
  output logic [DATA_WIDTH+ADR_WIDTH:0]   sum,
  output logic                            err_len,
  output logic                            err_to
);

  localparam int unsigned LEN_W = ADR_WIDTH + 1;
  localparam int unsigned SUM_W = DATA_WIDTH + ADR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_FLUSH = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     left_q, left_d;
  logic [ADR_WIDTH-1:0] datao_q, datao_d;
  logic [LEN_W-1:0]     rcnt_q, rcnt_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic                 vo_q, vo_d;
  logic                 fo_q, fo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_len_q, err_len_d;
  logic                 err_to_q, err_to_d;
  logic                 collect;
  logic                 wd_expire;

`ifdef NPS_ROM_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd_q;

  // Watchdog: zero outside WAIT, counts each WAIT cycle
  always_ff @(posedge clk) begin
    if (reset || (state_q != S_WAIT)) wd_q <= '0;
    else                              wd_q <= wd_q + WD_W'(1);
  end

  assign wd_expire = (state_q == S_WAIT) && (wd_q == WD_W'(TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  // Returned words count only while a sequence is in flight
  assign collect = vi && ((state_q == S_ISSUE) || (state_q == S_FLUSH) ||
                          (state_q == S_WAIT));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (len != '0) ? S_ISSUE : S_FLUSH;
      S_ISSUE: if (left_q == '0) state_d = S_FLUSH;
      S_FLUSH: state_d = S_WAIT;
      S_WAIT:  if (fi || wd_expire) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; strobes follow the upcoming state
  always_comb begin
    vo_d      = (state_d == S_ISSUE);
    fo_d      = (state_d == S_FLUSH);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    len_d     = len_q;
    left_d    = left_q;
    datao_d   = datao_q;
    rcnt_d    = rcnt_q;
    sum_d     = sum_q;
    err_len_d = err_len_q;
    err_to_d  = err_to_q;

    if (collect) begin
      rcnt_d = rcnt_q + LEN_W'(1);
      sum_d  = sum_q + SUM_W'(datai);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = len;
          rcnt_d    = '0;
          sum_d     = '0;
          err_len_d = 1'b0;
          err_to_d  = 1'b0;
          if (len != '0) begin
            datao_d = base;
            left_d  = len - LEN_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (left_q != '0) begin
          datao_d = datao_q + ADR_WIDTH'(1);
          left_d  = left_q - LEN_W'(1);
        end
      end
      S_WAIT: begin
        if (fi || wd_expire) begin
          err_len_d = (rcnt_d != len_q);
          err_to_d  = !fi && wd_expire;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      left_q    <= '0;
      datao_q   <= '0;
      rcnt_q    <= '0;
      sum_q     <= '0;
      vo_q      <= 1'b0;
      fo_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      len_q     <= len_d;
      left_q    <= left_d;
      datao_q   <= datao_d;
      rcnt_q    <= rcnt_d;
      sum_q     <= sum_d;
      vo_q      <= vo_d;
      fo_q      <= fo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
    end
  end

  assign vo      = vo_q;
  assign fo      = fo_q;
  assign datao   = datao_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rcnt    = rcnt_q;
  assign sum     = sum_q;
  assign err_len = err_len_q;
  assign err_to  = err_to_q;

endmodule

// File: tb/tb_nps_rom_seq.sv
// Bench for nps_rom_seq: a delay-line ROM model answers the address stream with
// data = address; expected addresses and completion results are queued when a
// sequence is launched and compared as the DUT produces them.
// Define NPS_ROM_SEQ_TIMEOUT_EN for both files to exercise the watchdog.
module tb_nps_rom_seq;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 9;
  localparam int unsigned TO = 16;

  typedef struct {
    logic [AW:0]    rcnt;
    logic [DW+AW:0] sum;
    logic           err_len;
    logic           err_to;
  } res_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   base;
  logic [AW:0]     len;
  logic            vo, fo, busy, done, err_len, err_to;
  logic [AW-1:0]   datao;
  logic            vi = 1'b0;
  logic            fi = 1'b0;
  logic [DW-1:0]   datai = '0;
  logic [AW:0]     rcnt;
  logic [DW+AW:0]  sum;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [AW-1:0] exp_addr[$];
  res_t          exp_res[$];

  // ROM model controls
  int dlat = 1;
  int flat = 1;
  int drop_k = -1;
  int vo_seen = 0;
  bit fi_en = 1'b1;
  int fi_pulse_cyc = -1;
  bit            pv[0:7];
  bit [AW-1:0]   pd[0:7];
  bit            pf[0:7];

  nps_rom_seq #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
    .vo(vo), .fo(fo), .datao(datao), .vi(vi), .fi(fi), .datai(datai),
    .busy(busy), .done(done), .rcnt(rcnt), .sum(sum),
    .err_len(err_len), .err_to(err_to)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ROM model: delay line from address/flush toward data/frame-end
  always @(negedge clk) begin
    for (int i = 7; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
      pf[i] = pf[i-1];
    end
    pv[0] = vo && (vo_seen != drop_k);
    pd[0] = datao;
    pf[0] = fo && fi_en;
    if (vo) vo_seen++;
    vi    = pv[dlat];
    datai = DW'(pd[dlat]);
    fi    = pf[flat] || (cyc == fi_pulse_cyc);
  end

  // Scoreboard: pop expected address per vo and expected result per done
  logic [AW-1:0] mon_a;
  res_t          mon_r;
  always @(negedge clk) begin
    if (vo) begin
      check_eq("addr_q_nonempty", 64'(exp_addr.size() != 0), 64'd1);
      if (exp_addr.size() != 0) begin
        mon_a = exp_addr.pop_front();
        check_eq("datao", 64'(datao), 64'(mon_a));
      end
    end
    if (done) begin
      check_eq("res_q_nonempty", 64'(exp_res.size() != 0), 64'd1);
      if (exp_res.size() != 0) begin
        mon_r = exp_res.pop_front();
        check_eq("rcnt", 64'(rcnt), 64'(mon_r.rcnt));
        check_eq("sum", 64'(sum), 64'(mon_r.sum));
        check_eq("err_len", 64'(err_len), 64'(mon_r.err_len));
        check_eq("err_to", 64'(err_to), 64'(mon_r.err_to));
      end
    end
  end

  task automatic run_seq(input int b, input int l, input int dl, input int fl,
                         input int drop, input bit fi_on, input int glitch_at,
                         input bit start_in_done);
    longint s;
    int     got_r, vo_n, fo_n, cyc_n, fo_cyc, done_cyc, a;
    bit     seen_done;
    res_t   r;
    @(negedge clk);
    dlat = dl; flat = fl; drop_k = drop; fi_en = fi_on; vo_seen = 0;
    fi_pulse_cyc = (glitch_at > 0) ? cyc + 2 + glitch_at : -1;
    s = 0; got_r = 0;
    for (int k = 0; k < l; k++) begin
      a = (b + k) % (1 << AW);
      exp_addr.push_back(AW'(a));
      if (k != drop) begin
        s += longint'(a);
        got_r++;
      end
    end
    r.rcnt    = (AW+1)'(got_r);
    r.sum     = (DW+AW+1)'(s);
    r.err_len = (got_r != l);
    r.err_to  = !fi_on;
    exp_res.push_back(r);
    start = 1'b1; base = AW'(b); len = (AW+1)'(l);
    @(negedge clk);
    vo_n = 0; fo_n = 0; cyc_n = 0; fo_cyc = -1; done_cyc = -1; seen_done = 1'b0;
    while (!seen_done && cyc_n < l + 200) begin
      start = 1'b0;
      if (cyc_n == 0) begin
        check_eq("busy_first", 64'(busy), 64'd1);
        check_eq("vo_first", 64'(vo), 64'(l != 0));
        check_eq("fo_first", 64'(fo), 64'(l == 0));
        check_eq("rcnt_clear", 64'(rcnt), 64'd0);
        check_eq("err_len_clear", 64'(err_len), 64'd0);
      end
      if (glitch_at > 0 && cyc_n == glitch_at) begin
        start = 1'b1; base = AW'(7); len = (AW+1)'(3);
      end
      if (vo) vo_n++;
      if (fo) begin fo_n++; fo_cyc = cyc_n; end
      if (done) begin
        seen_done = 1'b1;
        done_cyc = cyc_n;
      end else begin
        @(negedge clk);
        cyc_n++;
      end
    end
    check_eq("done_seen", 64'(seen_done), 64'd1);
    check_eq("vo_count", 64'(vo_n), 64'(l));
    check_eq("fo_count", 64'(fo_n), 64'd1);
    check_eq("fo_cycle", 64'(fo_cyc), 64'(l));
    check_eq("done_cycle", 64'(done_cyc), 64'(fi_on ? l + 1 + fl : l + 1 + int'(TO)));
    if (start_in_done) begin
      start = 1'b1; base = AW'(0); len = (AW+1)'(5);
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("done_one_cycle", 64'(done), 64'd0);
    check_eq("busy_after", 64'(busy), 64'd0);
    check_eq("err_len_hold", 64'(err_len), 64'(r.err_len));
    @(negedge clk);
    check_eq("idle_vo", 64'(vo), 64'd0);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("addr_q_empty", 64'(exp_addr.size()), 64'd0);
    check_eq("res_q_empty", 64'(exp_res.size()), 64'd0);
  endtask

  task automatic late_fi_check();
    @(negedge clk);
    fi_pulse_cyc = cyc + 1;
    repeat (3) @(negedge clk);
    check_eq("late_fi_done", 64'(done), 64'd0);
    check_eq("late_fi_busy", 64'(busy), 64'd0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    dlat = 1; flat = 1; drop_k = -1; fi_en = 1'b1; vo_seen = 0; fi_pulse_cyc = -1;
    for (int k = 0; k < 20; k++) exp_addr.push_back(AW'(100 + k));
    start = 1'b1; base = AW'(100); len = (AW+1)'(20);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_addr.delete();
    @(negedge clk);
    check_eq("rst_vo", 64'(vo), 64'd0);
    check_eq("rst_fo", 64'(fo), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_rcnt", 64'(rcnt), 64'd0);
    check_eq("rst_datao", 64'(datao), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("post_rst_rcnt", 64'(rcnt), 64'd0);
    check_eq("post_rst_sum", 64'(sum), 64'd0);
    check_eq("post_rst_fo", 64'(fo), 64'd0);
    check_eq("post_rst_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base = '0; len = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_vo", 64'(vo), 64'd0);
    check_eq("reset_fo", 64'(fo), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_datao", 64'(datao), 64'd0);
    check_eq("reset_rcnt", 64'(rcnt), 64'd0);
    check_eq("reset_sum", 64'(sum), 64'd0);
    check_eq("reset_err", 64'({err_len, err_to}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_seq(0, 512, 2, 1, -1, 1'b1, 0, 1'b0);
    check_eq("sweep_sum", 64'(sum), 64'd130816);
    run_seq(510, 4, 1, 1, -1, 1'b1, 0, 1'b0);
    run_seq(0, 0, 1, 1, -1, 1'b1, 0, 1'b0);
    run_seq(37, 8, 1, 3, 3, 1'b1, 0, 1'b0);
    run_seq(200, 10, 1, 2, -1, 1'b1, 4, 1'b1);
    late_fi_check();
    reset_mid();
    run_seq(5, 3, 1, 1, -1, 1'b1, 0, 1'b0);
`ifdef NPS_ROM_SEQ_TIMEOUT_EN
    run_seq(300, 6, 1, 1, -1, 1'b0, 0, 1'b0);
    late_fi_check();
    run_seq(40, 5, 2, 4, -1, 1'b1, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
